// File: rtl/mdr_pkg.sv
// rtl/mdr_pkg.sv - Shared size codes, FSM encodings and byte-enable helper for the MDR.
package mdr_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_RD_WAIT = 2'b01;
  localparam logic [1:0] S_WR_WAIT = 2'b10;

  // Widest byte-enable vector any instance may use; callers keep the low bits.
  localparam int MAX_BE_W = 64;

  function automatic logic [MAX_BE_W-1:0] be_for_size(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return MAX_BE_W'(1);
      SZ_HALF: return MAX_BE_W'(3);
      default: return '1;
    endcase
  endfunction

endpackage

// File: rtl/mdr_load_align.sv
// rtl/mdr_load_align.sv - Combinational sub-word extract with zero/sign extension.
module mdr_load_align
  import mdr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            size,
  input  logic                  sign,
  output logic [DATA_WIDTH-1:0] result
);

  logic ext_b;
  logic ext_h;

  assign ext_b = sign & data[7];
  assign ext_h = sign & data[15];

  // Per-bit loop keeps DATA_WIDTH=16 legal (no zero-width replication).
  always_comb begin
    result = data;
    for (int i = 8; i < DATA_WIDTH; i++) begin
      if (size == SZ_BYTE) begin
        result[i] = ext_b;
      end else if (size == SZ_HALF && i >= 16) begin
        result[i] = ext_h;
      end
    end
  end

endmodule

// File: rtl/mdr_mem_ctrl.sv
// rtl/mdr_mem_ctrl.sv - Memory Data Register with req/ready memory handshake.
// Define MDR_TIMEOUT_EN to abort transactions after MAX_WAIT wait cycles.
module mdr_mem_ctrl
  import mdr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 16
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    read,
  input  logic                    rd_start,
  input  logic                    wr_start,
  input  logic [1:0]              size,
  input  logic                    sign,
  input  logic [DATA_WIDTH-1:0]   BusMuxOut,
  input  logic [DATA_WIDTH-1:0]   Mdatain,
  input  logic                    mem_ready,
  output logic [DATA_WIDTH-1:0]   BusMuxIn,
  output logic [DATA_WIDTH-1:0]   Mdataout,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] mdr_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic                  err_q;
  logic [MAX_BE_W-1:0]   be_full;
  logic [1:0]            align_size;
  logic                  align_sign;
  logic [DATA_WIDTH-1:0] aligned;
  logic                  timeout_hit;

  assign be_full = be_for_size(size);

  // Direct loads in IDLE use live size/sign; memory reads use the values latched at start.
  assign align_size = (state == S_IDLE) ? size : size_q;
  assign align_sign = (state == S_IDLE) ? sign : sign_q;

  mdr_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .data   (Mdatain),
    .size   (align_size),
    .sign   (align_sign),
    .result (aligned)
  );

`ifdef MDR_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wait_cnt <= '0;
    end else if (state == S_IDLE) begin
      wait_cnt <= '0;
    end else if (!mem_ready) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign timeout_hit = (state != S_IDLE) && !mem_ready && (wait_cnt == CW'(MAX_WAIT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= S_IDLE;
      mdr_q   <= '0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      mem_be  <= '0;
      done    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_start) begin
            state   <= S_RD_WAIT;
            size_q  <= size;
            sign_q  <= sign;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            mem_be  <= '0;
          end else if (wr_start) begin
            state   <= S_WR_WAIT;
            size_q  <= size;
            sign_q  <= sign;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            mem_be  <= be_full[BE_W-1:0];
          end else if (enable) begin
            mdr_q <= read ? aligned : BusMuxOut;
          end
        end
        S_RD_WAIT, S_WR_WAIT: begin
          if (mem_ready || timeout_hit) begin
            if (mem_ready && state == S_RD_WAIT) begin
              mdr_q <= aligned;
            end
            state   <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
            done    <= mem_ready;
            err_q   <= ~mem_ready;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          mem_be  <= '0;
        end
      endcase
    end
  end

  assign BusMuxIn = mdr_q;
  assign Mdataout = mdr_q;
  assign busy     = (state != S_IDLE);
  assign err      = err_q;

endmodule
